credit_sender: RTL
==================

// Module: credit_sender
// PURPOSE
//  Upstream half of the credit-based link; drives the pop side of credit_sender into the push side of credit_receiver.
//  Accepts a ready/valid stream from the local producer and forwards one flit per credit held.
//  Tracks credits returned by the receiver and handles the reset handshake with it.
//  Sender reset and receiver reset are handled independently.
// PARAMETERS
//  WIDTH        8  flit data width in bits
//  MAX_CREDITS  4  credit counter ceiling, >=1
//  CW           -  localparam = $clog2(MAX_CREDITS+1), width of all credit fields
// PORTS
//  clk                    in   1      clock; all state updates on rising edge
//  rst                    in   1      asynchronous, active-high reset
//  push_valid             in   1      producer flit valid
//  push_ready             out  1      sender can take a flit this cycle
//  push_data              in   WIDTH  producer flit
//  pop_sender_in_reset    out  1      to receiver: sender is in reset/init
//  pop_receiver_in_reset  in   1      from receiver: receiver is in reset
//  pop_credit             in   1      one credit returned this cycle
//  pop_valid              out  1      flit valid toward receiver
//  pop_data               out  WIDTH  flit toward receiver
//  credit_initial         in   CW     credits granted at (re)start; clamped to MAX_CREDITS
//  credit_withhold        in   CW     credits held back from use; may change at any time
//  credit_count           out  CW     current credit register
//  credit_available       out  CW     usable credits = sat(credit_count - credit_withhold)
//  credit_error           out  1      sticky: a return would have exceeded MAX_CREDITS
// BEHAVIOUR
//  Reset values (rst=1, async): state=INIT, credit_count=0, pop_valid=0, pop_data=0, credit_error=0.
//  Outputs in reset: pop_sender_in_reset=1, push_ready=0.
//  FSM states: INIT, ACTIVE, RX_WAIT.
//   INIT: first clk edge with rst=0 loads credit_count=min(credit_initial,MAX_CREDITS).
//    That edge goes to RX_WAIT if pop_receiver_in_reset=1, otherwise to ACTIVE.
//   ACTIVE -> RX_WAIT when pop_receiver_in_reset=1. That edge sets credit_count=0 and pop_valid=0.
//    Any flit accepted on that same edge is dropped.
//   RX_WAIT -> ACTIVE on the first edge with pop_receiver_in_reset=0.
//    That edge reloads credit_count=min(credit_initial,MAX_CREDITS).
//  pop_sender_in_reset = (state==INIT); driven from a flop.
//  credit_available = (credit_count>credit_withhold) ? credit_count-credit_withhold : 0. Combinational.
//  push_ready = (state==ACTIVE) && (credit_available!=0). Must not depend on push_valid.
//  send = push_valid & push_ready.
//   On send: pop_valid<=1 and pop_data<=push_data next edge (1-cycle latency).
//   On no send: pop_valid<=0 and pop_data holds its value.
//   pop_valid is never asserted without a credit having been consumed.
//  Credit update in ACTIVE: next = credit_count - send + pop_credit.
//   send and pop_credit together leave the count unchanged. The counter never underflows.
//   If credit_count+pop_credit-send > MAX_CREDITS: the return is dropped, count holds, credit_error<=1.
//   credit_error stays set until rst.
//  In INIT and RX_WAIT, pop_credit is ignored and credit_error does not change.
//  A withhold raise above credit_count gives credit_available=0 and push_ready=0 in the same cycle.
//   Already-counted credits are not lost; lowering withhold restores them.
//  rst asserted mid-stream: every register goes to its reset value immediately, without waiting for clk.
// TESTING
//  1. Reset bring-up: credit_initial=3; assert rst, then release it.
//     -> pop_sender_in_reset=1 until the first edge after release, then 0; credit_count=3, push_ready=1.
//  2. Credit exhaustion: initial=2, push_valid=1 continuously, no returns.
//     -> exactly 2 pop_valid pulses with data in order; push_ready=0; credit_count=0.
//  3. Return plus send in the same cycle: count=1, push_valid=1, pop_credit=1.
//     -> count stays 1; pop_valid=1 the next cycle.
//  4. Withhold: count=3, withhold=2.
//     -> available=1, one flit sent.
//     Then withhold=4 -> available=0, push_ready=0. Then withhold=0 -> available=2.
//  5. Overflow: MAX_CREDITS=4, count=4, pop_credit=1.
//     -> count stays 4, credit_error=1 and stays 1 until rst.
//  6. Receiver reset mid-stream: pop_receiver_in_reset=1 for 3 cycles, initial=4.
//     -> pop_valid=0 and count=0 throughout; count=4 after release; push_ready=1 again.

Source files
------------

// File: rtl/credit_sender.sv
// credit_sender: upstream half of a credit-based link.
// Forwards one flit per held credit, tracks credits returned by the receiver
// and runs the reset handshake against an independently reset receiver.
module credit_sender #(
  parameter int WIDTH       = 8,
  parameter int MAX_CREDITS = 4,
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_sender_in_reset,
  input  logic             pop_receiver_in_reset,
  input  logic             pop_credit,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic [CW-1:0]    credit_initial,
  input  logic [CW-1:0]    credit_withhold,
  output logic [CW-1:0]    credit_count,
  output logic [CW-1:0]    credit_available,
  output logic             credit_error
);

  localparam logic [1:0] INIT    = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] RX_WAIT = 2'd2;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          send;
  logic [CW-1:0] credit_load;
  logic [CW:0]   credit_sum;

  // Usable credits, withhold applied with saturation at zero
  always_comb begin
    credit_available = '0;
    if (credit_count > credit_withhold)
      credit_available = credit_count - credit_withhold;
  end

  // Handshake, (re)start credit value and tentative credit update
  always_comb begin
    push_ready  = (state == ACTIVE) && (credit_available != '0);
    send        = push_valid && push_ready;
    credit_load = (credit_initial > MAX_C) ? MAX_C : credit_initial;
    credit_sum  = {1'b0, credit_count} + {{CW{1'b0}}, pop_credit}
                - {{CW{1'b0}}, send};
  end

  // Next-state logic for the reset handshake
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = pop_receiver_in_reset ? RX_WAIT : ACTIVE;
      ACTIVE:  if (pop_receiver_in_reset) state_nxt = RX_WAIT;
      RX_WAIT: if (!pop_receiver_in_reset) state_nxt = ACTIVE;
      default: state_nxt = INIT;
    endcase
  end

  // State register and registered in-reset indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= INIT;
      pop_sender_in_reset <= 1'b1;
    end else begin
      state               <= state_nxt;
      pop_sender_in_reset <= (state_nxt == INIT);
    end
  end

  // Credit counter, sticky overflow flag and outgoing flit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_count <= '0;
      credit_error <= 1'b0;
      pop_valid    <= 1'b0;
      pop_data     <= '0;
    end else begin
      pop_valid <= 1'b0;
      case (state)
        INIT: credit_count <= credit_load;
        ACTIVE: begin
          if (pop_receiver_in_reset) begin
            // receiver went away: any flit accepted on this edge is dropped
            credit_count <= '0;
          end else begin
            if (send) begin
              pop_valid <= 1'b1;
              pop_data  <= push_data;
            end
            if (credit_sum > {1'b0, MAX_C})
              credit_error <= 1'b1;
            else
              credit_count <= credit_sum[CW-1:0];
          end
        end
        RX_WAIT: if (!pop_receiver_in_reset) credit_count <= credit_load;
        default: credit_count <= '0;
      endcase
    end
  end

endmodule
